// File: rtl/dla_controller.sv
// dla_controller: DLA run sequencer (clear, seed, spawn/launch/walk loop) and VRAM port owner.
// Define DLA_CLEAR_EN to build the full-frame clear pass that runs before seeding.
module dla_controller #(
    parameter int unsigned AVN_AW       = 18,
    parameter int unsigned AVN_DW       = 16,
    parameter int unsigned HSIZE        = 640,
    parameter int unsigned VSIZE        = 480,
    parameter int unsigned NUM_PARTICLE = 1000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic [15:0]              particle_count,
    output logic [$clog2(HSIZE)-1:0] walk_init_x,
    output logic [$clog2(VSIZE)-1:0] walk_init_y,
    output logic                     walk_start,
    input  logic                     walk_done,
    input  logic [AVN_AW-1:0]        walk_avn_address,
    input  logic                     walk_avn_write,
    input  logic [AVN_DW-1:0]        walk_avn_writedata,
    output logic                     walk_avn_waitrequest,
    output logic [AVN_AW-1:0]        vram_avn_address,
    output logic                     vram_avn_write,
    output logic [AVN_DW-1:0]        vram_avn_writedata,
    input  logic                     vram_avn_waitrequest
);

    localparam int unsigned XW = $clog2(HSIZE);
    localparam int unsigned YW = $clog2(VSIZE);
    localparam logic [AVN_AW-1:0] SeedAddr  = AVN_AW'(HSIZE / 2 + (VSIZE / 2) * HSIZE);
    localparam logic [XW-1:0]     SeedX     = XW'(HSIZE / 2);
    localparam logic [YW-1:0]     SeedY     = YW'(VSIZE / 2);
    localparam logic [15:0]       LastCount = 16'(NUM_PARTICLE);

    typedef enum logic [6:0] {
        StIdle   = 7'b0000001,
        StClear  = 7'b0000010,
        StSeed   = 7'b0000100,
        StSpawn  = 7'b0001000,
        StLaunch = 7'b0010000,
        StWalk   = 7'b0100000,
        StFin    = 7'b1000000
    } state_e;

    state_e          state_q, state_d;
    logic [15:0]     lfsr_q, lfsr_d;
    logic [15:0]     count_q, count_d;
    logic [XW-1:0]   init_x_q, init_x_d;
    logic [YW-1:0]   init_y_q, init_y_d;
    logic [XW-1:0]   cand_x;
    logic [YW-1:0]   cand_y;
    logic            cand_ok;

`ifdef DLA_CLEAR_EN
    localparam logic [AVN_AW-1:0] ClearLast = AVN_AW'(HSIZE * VSIZE - 1);
    logic [AVN_AW-1:0] clr_cnt_q, clr_cnt_d;
`endif

    // Stuck detection is by the walker's freeze write, so walk_done is informational only.
    logic unused_walk_done;
    assign unused_walk_done = walk_done;

    assign lfsr_d  = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    assign cand_x  = lfsr_q[XW-1:0];
    assign cand_y  = lfsr_q[15 -: YW];
    assign cand_ok = (32'(cand_x) < HSIZE) && (32'(cand_y) < VSIZE) &&
                     !((cand_x == SeedX) && (cand_y == SeedY));

    assign particle_count = count_q;
    assign walk_init_x    = init_x_q;
    assign walk_init_y    = init_y_q;

    always_comb begin
        state_d              = state_q;
        count_d              = count_q;
        init_x_d             = init_x_q;
        init_y_d             = init_y_q;
`ifdef DLA_CLEAR_EN
        clr_cnt_d            = clr_cnt_q;
`endif
        busy                 = (state_q != StIdle);
        done                 = 1'b0;
        walk_start           = 1'b0;
        vram_avn_address     = '0;
        vram_avn_write       = 1'b0;
        vram_avn_writedata   = '0;
        walk_avn_waitrequest = 1'b1;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    count_d = '0;
`ifdef DLA_CLEAR_EN
                    state_d = StClear;
`else
                    state_d = StSeed;
`endif
                end
            end
            StClear: begin
`ifdef DLA_CLEAR_EN
                vram_avn_write   = 1'b1;
                vram_avn_address = clr_cnt_q;
                if (!vram_avn_waitrequest) begin
                    if (clr_cnt_q == ClearLast) begin
                        clr_cnt_d = '0;
                        state_d   = StSeed;
                    end else begin
                        clr_cnt_d = clr_cnt_q + AVN_AW'(1);
                    end
                end
`else
                state_d = StSeed;
`endif
            end
            StSeed: begin
                vram_avn_write     = 1'b1;
                vram_avn_address   = SeedAddr;
                vram_avn_writedata = '1;
                if (!vram_avn_waitrequest) state_d = StSpawn;
            end
            StSpawn: begin
                if (cand_ok) begin
                    init_x_d = cand_x;
                    init_y_d = cand_y;
                    state_d  = StLaunch;
                end
            end
            StLaunch: begin
                walk_start = 1'b1;
                state_d    = StWalk;
            end
            StWalk: begin
                vram_avn_address     = walk_avn_address;
                vram_avn_write       = walk_avn_write;
                vram_avn_writedata   = walk_avn_writedata;
                walk_avn_waitrequest = vram_avn_waitrequest;
                if (walk_avn_write && !vram_avn_waitrequest) begin
                    count_d = count_q + 16'd1;
                    state_d = (count_d == LastCount) ? StFin : StSpawn;
                end
            end
            StFin: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            lfsr_q   <= 16'hACE1;
            count_q  <= '0;
            init_x_q <= '0;
            init_y_q <= '0;
`ifdef DLA_CLEAR_EN
            clr_cnt_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            lfsr_q   <= lfsr_d;
            count_q  <= count_d;
            init_x_q <= init_x_d;
            init_y_q <= init_y_d;
`ifdef DLA_CLEAR_EN
            clr_cnt_q <= clr_cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_dla_controller.sv
// Bench for dla_controller on an 8x4 frame with three particles; VRAM writes are scoreboarded.
// Clear-pass expectations follow DLA_CLEAR_EN.
module tb_dla_controller;

    localparam int unsigned AW = 18;
    localparam int unsigned DW = 16;
    localparam int unsigned HS = 8;
    localparam int unsigned VS = 4;
    localparam int unsigned NP = 3;
    localparam int unsigned XW = $clog2(HS);
    localparam int unsigned YW = $clog2(VS);
    localparam logic [17:0] SEED_ADDR = 18'd20;
`ifdef DLA_CLEAR_EN
    localparam logic [17:0] FIRST_ADDR = 18'd0;
    localparam logic [17:0] STALL_ADDR = 18'd5;
    localparam logic [15:0] STALL_DATA = 16'h0000;
`else
    localparam logic [17:0] FIRST_ADDR = SEED_ADDR;
    localparam logic [17:0] STALL_ADDR = SEED_ADDR;
    localparam logic [15:0] STALL_DATA = 16'hFFFF;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          busy;
    logic          done;
    logic [15:0]   particle_count;
    logic [XW-1:0] walk_init_x;
    logic [YW-1:0] walk_init_y;
    logic          walk_start;
    logic          walk_done;
    logic [AW-1:0] walk_avn_address;
    logic          walk_avn_write;
    logic [DW-1:0] walk_avn_writedata;
    logic          walk_avn_waitrequest;
    logic [AW-1:0] vram_avn_address;
    logic          vram_avn_write;
    logic [DW-1:0] vram_avn_writedata;
    logic          vram_wait = 1'b0;

    always #5 clk = ~clk;

    dla_controller #(
        .AVN_AW(AW), .AVN_DW(DW), .HSIZE(HS), .VSIZE(VS), .NUM_PARTICLE(NP)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .start               (start),
        .busy                (busy),
        .done                (done),
        .particle_count      (particle_count),
        .walk_init_x         (walk_init_x),
        .walk_init_y         (walk_init_y),
        .walk_start          (walk_start),
        .walk_done           (walk_done),
        .walk_avn_address    (walk_avn_address),
        .walk_avn_write      (walk_avn_write),
        .walk_avn_writedata  (walk_avn_writedata),
        .walk_avn_waitrequest(walk_avn_waitrequest),
        .vram_avn_address    (vram_avn_address),
        .vram_avn_write      (vram_avn_write),
        .vram_avn_writedata  (vram_avn_writedata),
        .vram_avn_waitrequest(vram_wait)
    );

    int n_cmp = 0;
    int n_err = 0;
    logic [33:0] exp_q[$];
    int  exp_cnt, n_starts, clr_beats, hold_cycles, stall_cnt, done_pulses;
    bit  stall_arm, abort;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // VRAM slave model: stalls the chosen beat three cycles and scoreboards accepted beats.
    always @(negedge clk) begin
        vram_wait = 1'b0;
        if (stall_arm && vram_avn_write && vram_avn_address == STALL_ADDR &&
            vram_avn_writedata == STALL_DATA) begin
            hold_cycles++;
            if (stall_cnt < 3) begin
                vram_wait = 1'b1;
                stall_cnt++;
            end
        end
        if (done) done_pulses++;
        if (vram_avn_write && !vram_wait) begin
            if (exp_q.size() == 0) begin
                check("sb_extra_write", 64'(exp_q.size()), 64'd1);
            end else begin
                logic [33:0] e;
                e = exp_q.pop_front();
                check("vram_addr", 64'(vram_avn_address), 64'(e[33:16]));
                check("vram_data", 64'(vram_avn_writedata), 64'(e[15:0]));
                if (vram_avn_writedata == 16'h0000) clr_beats++;
            end
        end
    end

    // Walker model: ten cycles after launch it reports stuck and issues one freeze write.
    initial begin : walker
        logic [XW-1:0] wx;
        logic [YW-1:0] wy;
        bit aborted, acc;
        walk_done = 1'b0;
        walk_avn_write = 1'b0;
        walk_avn_address = '0;
        walk_avn_writedata = '0;
        @(posedge clk); #1;
        forever begin
            if (walk_start && !abort) begin
                n_starts++;
                wx = walk_init_x;
                wy = walk_init_y;
                check("init_x_range", 64'(32'(wx) < HS), 64'd1);
                check("init_y_range", 64'(32'(wy) < VS), 64'd1);
                check("init_not_seed", 64'(!(wx == 3'd4 && wy == 2'd2)), 64'd1);
                @(posedge clk); #1;
                check("walk_start_pulse", 64'(walk_start), 64'd0);
                aborted = abort;
                for (int i = 0; i < 8 && !aborted; i++) begin
                    @(posedge clk); #1;
                    aborted = abort;
                end
                if (!aborted) begin
                    walk_done = 1'b1;
                    @(posedge clk); #1;
                    walk_done = 1'b0;
                    walk_avn_address = AW'(32'(wy) * HS + 32'(wx));
                    walk_avn_writedata = 16'hFFFF;
                    walk_avn_write = 1'b1;
                    exp_q.push_back({walk_avn_address, 16'hFFFF});
                    acc = 1'b0;
                    for (int i = 0; i < 50 && !acc; i++) begin
                        @(negedge clk);
                        if (!walk_avn_waitrequest) acc = 1'b1;
                    end
                    check("walk_accept", 64'(acc), 64'd1);
                    @(posedge clk); #1;
                    exp_cnt++;
                    check("particle_count", 64'(particle_count), 64'(exp_cnt));
                    // Keep requesting after the freeze: the port must stay closed.
                    @(negedge clk);
                    check("nowalk_vram_write", 64'(vram_avn_write), 64'd0);
                    check("nowalk_waitreq", 64'(walk_avn_waitrequest), 64'd1);
                    @(posedge clk); #1;
                end
                walk_avn_write = 1'b0;
            end else begin
                @(posedge clk); #1;
            end
        end
    end

    task automatic check_reset_values();
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_walk_start", 64'(walk_start), 64'd0);
        check("rst_vram_write", 64'(vram_avn_write), 64'd0);
        check("rst_count", 64'(particle_count), 64'd0);
        check("rst_init_x", 64'(walk_init_x), 64'd0);
        check("rst_init_y", 64'(walk_init_y), 64'd0);
    endtask

    task automatic run_start(input bit stall);
        exp_cnt = 0;
        n_starts = 0;
        clr_beats = 0;
        hold_cycles = 0;
        stall_cnt = 0;
        stall_arm = stall;
`ifdef DLA_CLEAR_EN
        for (int a = 0; a < int'(HS * VS); a++) exp_q.push_back({AW'(a), 16'h0000});
`endif
        exp_q.push_back({SEED_ADDR, 16'hFFFF});
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_after_start", 64'(busy), 64'd1);
        check("first_write", 64'(vram_avn_write), 64'd1);
        check("first_addr", 64'(vram_avn_address), 64'(FIRST_ADDR));
    endtask

    task automatic wait_done(input bit poke);
        bit seen = 1'b0;
        for (int i = 0; i < 3000 && !seen; i++) begin
            @(posedge clk); #1;
            start = (poke && i == 20);
            if (done) seen = 1'b1;
        end
        start = 1'b0;
        check("done_seen", 64'(seen), 64'd1);
        if (seen) begin
            check("busy_in_fin", 64'(busy), 64'd1);
            check("count_at_done", 64'(particle_count), 64'(NP));
            check("starts_per_run", 64'(n_starts), 64'(NP));
            @(posedge clk); #1;
            check("done_one_cycle", 64'(done), 64'd0);
            check("busy_after_done", 64'(busy), 64'd0);
        end
    endtask

    initial begin : main
        bit reached;
        rst = 1'b1;
        start = 1'b0;
        stall_arm = 1'b0;
        abort = 1'b0;
        done_pulses = 0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_values();
        rst = 1'b0;
        @(posedge clk); #1;

        // Run 1: stalled beat, ignored mid-run start.
        run_start(1'b1);
        wait_done(1'b1);
        stall_arm = 1'b0;
`ifdef DLA_CLEAR_EN
        check("clear_beats", 64'(clr_beats), 64'd32);
`endif
        check("stall_hold_cycles", 64'(hold_cycles), 64'd4);
        check("done_pulses_run1", 64'(done_pulses), 64'd1);
        check("sb_drained_run1", 64'(exp_q.size()), 64'd0);
        repeat (3) @(posedge clk);
        #1;

        // Run 2: reset while walking particle 2.
        run_start(1'b0);
        reached = 1'b0;
        for (int i = 0; i < 2000 && !reached; i++) begin
            @(posedge clk); #1;
            if (n_starts == 2) reached = 1'b1;
        end
        check("reach_particle2", 64'(reached), 64'd1);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        abort = 1'b1;
        @(posedge clk); #1;
        check_reset_values();
        rst = 1'b0;
        check("sb_empty_at_rst", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1;
        abort = 1'b0;

        // Run 3: full run after abort, count restarts at zero.
        run_start(1'b0);
        check("count_restart", 64'(particle_count), 64'd0);
        wait_done(1'b0);
        check("done_pulses_total", 64'(done_pulses), 64'd2);
        check("sb_drained_run3", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
